// File: rtl/sdram_port_arbiter.sv
// Two-port round-robin arbiter in front of a shared SDRAM/VGA controller read/write port.
// Optional WAIT-state abort with err pulse when ARB_TIMEOUT_EN is defined.
module sdram_port_arbiter #(
    parameter int unsigned ADDR_W     = 22,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned ACCESS_LAT = 4,
    parameter int unsigned TIMEOUT    = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    input  logic              a_we,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    input  logic              b_we,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    output logic              err,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_rdwr,
    output logic              mem_clk,
    input  logic              mem_lock
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    if (ACCESS_LAT < 1 || ACCESS_LAT > 15 || TIMEOUT < 1) begin : g_bad_param
        $error("sdram_port_arbiter: ACCESS_LAT must be 1..15 and TIMEOUT >= 1");
    end

    logic [1:0] state;
    logic [3:0] lat_cnt;
    logic       last_b;   // 1 = B was granted last
    logic       gnt_b;    // requester owning the in-flight access
    logic       pick_b;
    logic       normal_end;
    logic       abort_end;

    // B wins only when A is idle or A was served last.
    assign pick_b     = b_req && (!a_req || !last_b);
    assign normal_end = (lat_cnt == 4'd0) && !mem_lock;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] wait_cnt;
    logic            err_q;

    assign abort_end = !normal_end && (wait_cnt == TO_W'(TIMEOUT - 1));
    assign err       = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= (state == WAIT) && abort_end;
            if (state == ISSUE) begin
                wait_cnt <= '0;
            end else if (state == WAIT && !abort_end) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end
`else
    assign abort_end = 1'b0;
    assign err       = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            lat_cnt     <= 4'd0;
            last_b      <= 1'b1;
            gnt_b       <= 1'b0;
            a_ack       <= 1'b0;
            b_ack       <= 1'b0;
            a_rdata     <= '0;
            b_rdata     <= '0;
            mem_address <= '0;
            mem_wdata   <= '0;
            mem_rdwr    <= 1'b0;
            mem_clk     <= 1'b0;
        end else begin
            a_ack   <= 1'b0;
            b_ack   <= 1'b0;
            mem_clk <= 1'b0;
            case (state)
                IDLE: begin
                    if (!mem_lock && (a_req || b_req)) begin
                        gnt_b       <= pick_b;
                        mem_address <= pick_b ? b_addr : a_addr;
                        mem_wdata   <= pick_b ? b_wdata : a_wdata;
                        mem_rdwr    <= pick_b ? b_we : a_we;
                        // Strobe is registered so it is high for the whole ISSUE cycle.
                        mem_clk     <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    lat_cnt <= 4'(ACCESS_LAT);
                    state   <= WAIT;
                end
                WAIT: begin
                    if (lat_cnt != 4'd0) begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                    if (normal_end || abort_end) begin
                        state  <= DONE;
                        last_b <= gnt_b;
                        if (gnt_b) begin
                            b_ack <= 1'b1;
                        end else begin
                            a_ack <= 1'b1;
                        end
                        if (normal_end && !mem_rdwr) begin
                            if (gnt_b) begin
                                b_rdata <= mem_rdata;
                            end else begin
                                a_rdata <= mem_rdata;
                            end
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
